proc_sequencer: RTL and testbench



---
 rtl/proc_sequencer.sv | 128 ++++++++++++
 tb/tb_proc_sequencer.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/proc_sequencer.sv
// rtl/proc_sequencer.sv - T0..T3 control sequencer for the 16-bit bus processor
module proc_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [15:0] din,
  output logic [15:0] ir,
  output logic        ir_in,
  output logic [7:0]  r_in,
  output logic [7:0]  r_out,
  output logic        a_in,
  output logic        g_in,
  output logic        g_out,
  output logic        din_out,
  output logic        sub,
  output logic        done
);

  typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} step_e;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  step_e       step_q, step_d;
  logic [15:0] ir_q, ir_d;

  logic [2:0] opcode;
  logic [7:0] x_onehot;
  logic [7:0] y_onehot;

  assign opcode   = ir_q[15:13];
  assign x_onehot = 8'b0000_0001 << ir_q[12:10];
  assign y_onehot = 8'b0000_0001 << ir_q[9:7];

  // Raw decode before reset gating.
  logic       ir_in_c, a_in_c, g_in_c, g_out_c, din_out_c, sub_c, done_c;
  logic [7:0] r_in_c, r_out_c;

  // Step and instruction register; reset abandons any instruction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q <= T0;
      ir_q   <= 16'h0000;
    end else begin
      step_q <= step_d;
      ir_q   <= ir_d;
    end
  end

  // Next step and control strobes decoded from the current step and opcode.
  always_comb begin
    step_d    = step_q;
    ir_d      = ir_q;
    ir_in_c   = 1'b0;
    r_in_c    = 8'h00;
    r_out_c   = 8'h00;
    a_in_c    = 1'b0;
    g_in_c    = 1'b0;
    g_out_c   = 1'b0;
    din_out_c = 1'b0;
    sub_c     = 1'b0;
    done_c    = 1'b0;
    case (step_q)
      T0: begin
        ir_in_c = run;
        if (run) begin
          ir_d   = din;
          step_d = T1;
        end
      end
      T1: begin
        case (opcode)
          OP_MV: begin
            r_out_c = y_onehot;
            r_in_c  = x_onehot;
            done_c  = 1'b1;
            step_d  = T0;
          end
          OP_MVI: begin
            din_out_c = 1'b1;
            r_in_c    = x_onehot;
            done_c    = 1'b1;
            step_d    = T0;
          end
          OP_ADD, OP_SUB: begin
            r_out_c = x_onehot;
            a_in_c  = 1'b1;
            step_d  = T2;
          end
          default: begin
            done_c = 1'b1;
            step_d = T0;
          end
        endcase
      end
      T2: begin
        r_out_c = y_onehot;
        g_in_c  = 1'b1;
        sub_c   = ir_q[13];
        step_d  = T3;
      end
      T3: begin
        g_out_c = 1'b1;
        r_in_c  = x_onehot;
        done_c  = 1'b1;
        step_d  = T0;
      end
      default: step_d = T0;
    endcase
  end

  // Every strobe is forced low while reset is held, independent of run.
  always_comb begin
    ir      = ir_q;
    ir_in   = ir_in_c   & ~rst;
    r_in    = r_in_c    & {8{~rst}};
    r_out   = r_out_c   & {8{~rst}};
    a_in    = a_in_c    & ~rst;
    g_in    = g_in_c    & ~rst;
    g_out   = g_out_c   & ~rst;
    din_out = din_out_c & ~rst;
    sub     = sub_c     & ~rst;
    done    = done_c    & ~rst;
  end

endmodule

// File: tb/tb_proc_sequencer.sv
// tb/tb_proc_sequencer.sv - directed-vector bench for proc_sequencer
module tb_proc_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run = 1'b0;
  logic [15:0] din = 16'h0000;
  logic [15:0] ir;
  logic        ir_in, a_in, g_in, g_out, din_out, sub, done;
  logic [7:0]  r_in, r_out;

  int vectors = 0;
  int miscompares = 0;

  proc_sequencer dut (
    .clk(clk), .rst(rst), .run(run), .din(din), .ir(ir),
    .ir_in(ir_in), .r_in(r_in), .r_out(r_out), .a_in(a_in),
    .g_in(g_in), .g_out(g_out), .din_out(din_out), .sub(sub), .done(done)
  );

  always #5 clk = ~clk;

  logic [22:0] obs;
  assign obs = {ir_in, r_in, r_out, a_in, g_in, g_out, din_out, sub, done};

  function automatic logic [22:0] pk(input logic iri, input logic [7:0] ri,
                                     input logic [7:0] ro, input logic a,
                                     input logic g, input logic go, input logic dout,
                                     input logic s, input logic d);
    return {iri, ri, ro, a, g, go, dout, s, d};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge, then settle before sampling.
  task automatic nx;
    @(negedge clk);
    #1;
  endtask

  localparam logic [22:0] ZERO = 23'h0;

  initial begin
    // Reset with run high and an add word on din.
    run = 1'b1; din = 16'h4600;
    #1 rst = 1'b1;
    nx; nx;
    chk("rst_strobes", {9'h0, obs}, {9'h0, ZERO});
    chk("rst_ir", {16'h0, ir}, 32'h0);

    // Release: T0 with run=1 raises ir_in immediately.
    rst = 1'b0; #1;
    chk("rel_ir_in", {9'h0, obs}, {9'h0, pk(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0)});
    run = 1'b0; #1;
    chk("t0_idle", {9'h0, obs}, {9'h0, ZERO});

    // mv R2,R5
    din = 16'h0A80; run = 1'b1;
    nx;
    run = 1'b0; din = 16'hFFFF; #1;
    chk("mv_ir", {16'h0, ir}, 32'h0A80);
    chk("mv_t1", {9'h0, obs}, {9'h0, pk(0, 8'h04, 8'h20, 0, 0, 0, 0, 0, 1)});
    nx;
    chk("mv_t0", {9'h0, obs}, {9'h0, ZERO});

    // mvi R3 with immediate 0x1234 on din in T1
    din = 16'h2C00; run = 1'b1;
    nx;
    din = 16'h1234; run = 1'b0; #1;
    chk("mvi_ir", {16'h0, ir}, 32'h2C00);
    chk("mvi_t1", {9'h0, obs}, {9'h0, pk(0, 8'h08, 8'h00, 0, 0, 0, 1, 0, 1)});
    nx;
    chk("mvi_t0", {9'h0, obs}, {9'h0, ZERO});

    // add R1,R4; run toggled mid-instruction must be ignored
    din = 16'h4600; run = 1'b1;
    nx;
    run = 1'b0; din = 16'h0000; #1;
    chk("add_t1", {9'h0, obs}, {9'h0, pk(0, 8'h00, 8'h02, 1, 0, 0, 0, 0, 0)});
    run = 1'b1;
    nx;
    chk("add_t2", {9'h0, obs}, {9'h0, pk(0, 8'h00, 8'h10, 0, 1, 0, 0, 0, 0)});
    run = 1'b0;
    nx;
    chk("add_t3", {9'h0, obs}, {9'h0, pk(0, 8'h02, 8'h00, 0, 0, 1, 0, 0, 1)});
    chk("add_ir", {16'h0, ir}, 32'h4600);

    // sub R7,R0 with run held high from T3 of the add onward
    run = 1'b1; din = 16'h7C00;
    nx;
    chk("sub_t0", {9'h0, obs}, {9'h0, pk(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0)});
    nx;
    din = 16'h8000; #1;
    chk("sub_ir", {16'h0, ir}, 32'h7C00);
    chk("sub_t1", {9'h0, obs}, {9'h0, pk(0, 8'h00, 8'h80, 1, 0, 0, 0, 0, 0)});
    nx;
    chk("sub_t2", {9'h0, obs}, {9'h0, pk(0, 8'h00, 8'h01, 0, 1, 0, 0, 1, 0)});
    nx;
    chk("sub_t3", {9'h0, obs}, {9'h0, pk(0, 8'h80, 8'h00, 0, 0, 1, 0, 0, 1)});
    nx;
    chk("b2b_t0", {9'h0, obs}, {9'h0, pk(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0)});

    // No-op 0x8000 loaded back-to-back
    nx;
    run = 1'b0; #1;
    chk("nop_ir", {16'h0, ir}, 32'h8000);
    chk("nop_t1", {9'h0, obs}, {9'h0, pk(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1)});
    nx;
    chk("nop_t0", {9'h0, obs}, {9'h0, ZERO});

    // add R1,R4 abandoned by reset in T2
    din = 16'h4600; run = 1'b1;
    nx;
    run = 1'b0; #1;
    chk("abort_t1", {9'h0, obs}, {9'h0, pk(0, 8'h00, 8'h02, 1, 0, 0, 0, 0, 0)});
    nx;
    chk("abort_t2", {9'h0, obs}, {9'h0, pk(0, 8'h00, 8'h10, 0, 1, 0, 0, 0, 0)});
    rst = 1'b1; #1;
    chk("abort_rst", {9'h0, obs}, {9'h0, ZERO});
    chk("abort_ir", {16'h0, ir}, 32'h0);
    nx;
    chk("abort_hold", {9'h0, obs}, {9'h0, ZERO});
    rst = 1'b0; #1;
    chk("abort_rel", {9'h0, obs}, {9'h0, ZERO});
    nx;
    chk("abort_nodone", {31'h0, done}, 32'h0);

    // Recovery: a fresh mv R0,R7 runs normally after the abort
    din = 16'h0380; run = 1'b1;
    nx;
    run = 1'b0; #1;
    chk("recov_t1", {9'h0, obs}, {9'h0, pk(0, 8'h01, 8'h80, 0, 0, 0, 0, 0, 1)});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
